phase_freq_detector: RTL
========================

PHASE_FREQ_DETECTOR -- requirements
Module: phase_freq_detector

Interface
REQ-001 SHALL have parameters, one per line:
- ERROR_WIDTH, 8, signed error width
- COUNT_WIDTH, 10, interval counter width
- LOCK_TOL, 2, lock tolerance magnitude
- LOCK_COUNT, 16, consecutive in-tolerance updates needed to declare lock
REQ-002 gen_clk_i  input  1  single clock for all logic
REQ-003 reset_i  input  1  synchronous, active-high reset
REQ-004 ref_i  input  1  reference clock level, already synchronous to gen_clk_i
REQ-005 fb_i  input  1  DCO feedback (divided) level, already synchronous to gen_clk_i
REQ-006 error_o  output  ERROR_WIDTH  signed phase error, held between updates, feeds loop filter error input
REQ-007 valid_o  output  1  one-cycle pulse when error_o updates
REQ-008 lock_o  output  1  loop-locked flag

Function
REQ-009 SHALL detect rising edges as input high now and registered copy low; detection cycle = cycle the high level is first sampled.
REQ-010 SHALL use FSM states IDLE, REF_LEAD, FB_LEAD.
REQ-011 IDLE: ref edge only -> REF_LEAD, counter=0; fb edge only -> FB_LEAD, counter=0; both in same cycle -> stay IDLE, emit error 0.
REQ-012 In REF_LEAD/FB_LEAD, counter SHALL increment by 1 every cycle without a closing edge.
REQ-013 REF_LEAD + fb edge at counter value N: emit error=+(N+1), i.e. cycles between detections; FB_LEAD + ref edge: emit -(N+1).
REQ-014 Sign rule: positive error = feedback lags reference (DCO must speed up).
REQ-015 Closing edge with simultaneous new leading edge (e.g. REF_LEAD, ref and fb both rise): measurement closes per REQ-013, next state REF_LEAD (resp. FB_LEAD) with counter=0.
REQ-016 Closing edge alone: return to IDLE.
REQ-017 Cycle slip: repeated leading edge without closing edge (ref edge in REF_LEAD, fb edge in FB_LEAD) SHALL emit +MAX (resp. -MAX), stay in state, counter=0.
REQ-018 Timeout: counter reaching 2^COUNT_WIDTH-1 SHALL emit +MAX in REF_LEAD / -MAX in FB_LEAD and return to IDLE; counter never wraps.
REQ-019 MAX = 2^(ERROR_WIDTH-1)-1; magnitudes above MAX SHALL saturate to +/-MAX; -2^(ERROR_WIDTH-1) never output.
REQ-020 error_o and valid_o SHALL be registered: update on the cycle after the event cycle; valid_o high exactly one cycle per event; error_o otherwise holds.
REQ-021 Lock counter: each emitted error with |error|<=LOCK_TOL increments (saturating at LOCK_COUNT); any emitted error outside tolerance clears it and lock_o.
REQ-022 lock_o SHALL assert, registered, on the cycle valid_o carries the LOCK_COUNT-th consecutive in-tolerance error; lock_o unchanged in cycles without valid_o.

Reset
REQ-023 While reset_i high at a gen_clk_i edge: state IDLE, counter 0, lock counter 0, error_o 0, valid_o 0, lock_o 0.
REQ-024 During reset, edge-history registers SHALL load current ref_i/fb_i so inputs held high through reset release produce no edge.
REQ-025 Reset asserted mid-measurement SHALL abort it with no valid_o pulse, then take effect per REQ-023 next edge.

Verification
REQ-026 Ref edge cycle t, fb edge cycle t+3 -> valid_o at t+4 only, error_o=+3 held afterward.
REQ-027 Fb edge cycle t, ref edge cycle t+200, ERROR_WIDTH=8 -> error_o=-127 (saturated), valid_o one cycle.
REQ-028 Ref and fb edges same cycle from IDLE -> error_o=0, valid_o one cycle, state IDLE.
REQ-029 Two ref edges 50 cycles apart, no fb -> second ref edge yields error_o=+127; fb edge 4 cycles later yields +4.
REQ-030 Ref edge, no fb for 1023 cycles (COUNT_WIDTH=10) -> +127 emitted, FSM IDLE; 16 updates of +1 then lock_o=1; one update of +5 -> lock_o=0.
REQ-031 Reset asserted 2 cycles into REF_LEAD with ref_i held high -> no valid_o; all outputs 0; no edge detected after release.

Source files
------------

// File: rtl/phase_freq_detector_if.sv
// Reference/feedback levels in, signed phase error with strobe and lock flag out.
interface phase_freq_detector_if #(
   parameter int ERROR_WIDTH = 8
);
   logic                          ref_i;
   logic                          fb_i;
   logic signed [ERROR_WIDTH-1:0] error_o;
   logic                          valid_o;
   logic                          lock_o;

   modport master (
      output ref_i,
      output fb_i,
      input  error_o,
      input  valid_o,
      input  lock_o
   );

   modport slave (
      input  ref_i,
      input  fb_i,
      output error_o,
      output valid_o,
      output lock_o
   );
endinterface

// File: rtl/phase_freq_detector.sv
// Counter-based phase/frequency detector: measures cycles between ref and fb rising
// edges, emits a saturated signed error per measurement and tracks loop lock.
//
// state    | meaning
// IDLE     | no measurement open, waiting for a leading edge
// REF_LEAD | ref rose first, counting until fb rises (positive error)
// FB_LEAD  | fb rose first, counting until ref rises (negative error)
module phase_freq_detector #(
   parameter int ERROR_WIDTH = 8,
   parameter int COUNT_WIDTH = 10,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_COUNT  = 16
) (
   input  logic                 gen_clk_i,
   input  logic                 reset_i,
   phase_freq_detector_if.slave pfd
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REF_LEAD = 2'd1;
   localparam logic [1:0] FB_LEAD  = 2'd2;

   localparam int MW  = (COUNT_WIDTH + 1 > ERROR_WIDTH) ? COUNT_WIDTH + 1 : ERROR_WIDTH;
   localparam int LCW = $clog2(LOCK_COUNT + 1);
   localparam logic [MW-1:0]          MAX_M   = MW'((2 ** (ERROR_WIDTH - 1)) - 1);
   localparam logic [MW-1:0]          TOL_M   = MW'(LOCK_TOL);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [LCW-1:0]         LOCK_N  = LCW'(LOCK_COUNT);

   logic                          ref_q, fb_q;
   logic                          ref_edge, fb_edge;
   logic [1:0]                    state_q, state_d;
   logic [COUNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic                          ev_d, neg_d;
   logic [MW-1:0]                 mag_d, mag_sat;
   logic signed [ERROR_WIDTH-1:0] mag_e, err_d;
   logic                          in_tol;
   logic signed [ERROR_WIDTH-1:0] error_q;
   logic                          valid_q, lock_q;
   logic [LCW-1:0]                lock_cnt_q, lock_inc;

   assign ref_edge = pfd.ref_i & ~ref_q;
   assign fb_edge  = pfd.fb_i & ~fb_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev_d    = 1'b0;
      neg_d   = 1'b0;
      mag_d   = MW'(cnt_q) + MW'(1);
      case (state_q)
         IDLE: begin
            if (ref_edge && fb_edge) begin
               ev_d  = 1'b1;
               mag_d = '0;
            end else if (ref_edge) begin
               state_d = REF_LEAD;
               cnt_d   = '0;
            end else if (fb_edge) begin
               state_d = FB_LEAD;
               cnt_d   = '0;
            end
         end
         REF_LEAD: begin
            if (fb_edge) begin
               ev_d    = 1'b1;
               cnt_d   = '0;
               state_d = ref_edge ? REF_LEAD : IDLE;
            end else if (ref_edge) begin
               ev_d  = 1'b1;
               mag_d = MAX_M;
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               ev_d    = 1'b1;
               mag_d   = MAX_M;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FB_LEAD: begin
            neg_d = 1'b1;
            if (ref_edge) begin
               ev_d    = 1'b1;
               cnt_d   = '0;
               state_d = fb_edge ? FB_LEAD : IDLE;
            end else if (fb_edge) begin
               ev_d  = 1'b1;
               mag_d = MAX_M;
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               ev_d    = 1'b1;
               mag_d   = MAX_M;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Saturating to +/-MAX keeps the most negative code out of the loop filter.
   assign mag_sat  = (mag_d > MAX_M) ? MAX_M : mag_d;
   assign mag_e    = $signed(ERROR_WIDTH'(mag_sat));
   assign err_d    = neg_d ? -mag_e : mag_e;
   assign in_tol   = (mag_sat <= TOL_M);
   assign lock_inc = (lock_cnt_q == LOCK_N) ? lock_cnt_q : lock_cnt_q + 1'b1;

   always_ff @(posedge gen_clk_i) begin
      ref_q <= pfd.ref_i;
      fb_q  <= pfd.fb_i;
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         error_q    <= '0;
         valid_q    <= 1'b0;
         lock_q     <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= ev_d;
         if (ev_d) begin
            error_q <= err_d;
            if (in_tol) begin
               lock_cnt_q <= lock_inc;
               lock_q     <= (lock_inc == LOCK_N);
            end else begin
               lock_cnt_q <= '0;
               lock_q     <= 1'b0;
            end
         end
      end
   end

   assign pfd.error_o = error_q;
   assign pfd.valid_o = valid_q;
   assign pfd.lock_o  = lock_q;
endmodule
